// File: rtl/food_pos_if.sv
// Handshake bundle between a food requester / occupancy map and food_pos_gen.
// Latency: n/a (wires only).
// Backpressure: none; req is ignored by the generator while busy.
interface food_pos_if #(
    parameter int W = 7
);
    logic         req;
    logic         busy;
    logic         valid;
    logic         fail;
    logic [W-1:0] pos_x;
    logic [W-1:0] pos_y;
    logic         occ_req;
    logic [W-1:0] occ_x;
    logic [W-1:0] occ_y;
    logic         occ_hit;

    modport master (
        output req, occ_hit,
        input  busy, valid, fail, pos_x, pos_y, occ_req, occ_x, occ_y
    );

    modport slave (
        input  req, occ_hit,
        output busy, valid, fail, pos_x, pos_y, occ_req, occ_x, occ_y
    );
endinterface

// File: rtl/food_pos_gen.sv
// Draws a random free cell from a free-running LFSR, checking it against the snake-body map.
// Latency: 4 cycles req->valid when the first candidate is in range and free; 1 more per out-of-range draw, 3 more per occupied hit.
// Backpressure: none; req is ignored while busy, gives up with fail=1 after MAX_TRIES rejections.
module food_pos_gen #(
    parameter int          W         = 7,
    parameter int          MAX_X     = 96,
    parameter int          MAX_Y     = 64,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_TRIES = 16
) (
    input logic       clk,
    input logic       rst,
    food_pos_if.slave bus
);
    localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam int          TW         = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0] TRIES_LAST = TW'(MAX_TRIES - 1);
    localparam logic [31:0] MAX_X_U    = MAX_X;
    localparam logic [31:0] MAX_Y_U    = MAX_Y;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        QUERY = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [TW-1:0] tries;
    logic [W-1:0]  cand_x;
    logic [W-1:0]  cand_y;
    logic          busy;
    logic          valid;
    logic          fail;
    logic          occ_req;
    logic [W-1:0]  occ_x;
    logic [W-1:0]  occ_y;
    logic [W-1:0]  pos_x;
    logic [W-1:0]  pos_y;

    logic [W-1:0]  new_x;
    logic [W-1:0]  new_y;
    logic          in_range;
    logic          last_try;

    assign new_x    = lfsr[W-1:0];
    assign new_y    = lfsr[2*W-1:W];
    assign in_range = (32'(new_x) < MAX_X_U) && (32'(new_y) < MAX_Y_U);
    assign last_try = (tries == TRIES_LAST);

    // Free-running regardless of FSM state so successive requests see fresh candidates.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED_EFF;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tries   <= '0;
            cand_x  <= '0;
            cand_y  <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            fail    <= 1'b0;
            occ_req <= 1'b0;
            occ_x   <= '0;
            occ_y   <= '0;
            pos_x   <= '0;
            pos_y   <= '0;
        end else begin
            valid   <= 1'b0;
            fail    <= 1'b0;
            occ_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        state <= DRAW;
                        tries <= '0;
                        busy  <= 1'b1;
                    end
                end
                DRAW: begin
                    if (in_range) begin
                        cand_x  <= new_x;
                        cand_y  <= new_y;
                        occ_x   <= new_x;
                        occ_y   <= new_y;
                        occ_req <= 1'b1;
                        state   <= QUERY;
                    end else if (last_try) begin
                        valid <= 1'b1;
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tries <= tries + 1'b1;
                    end
                end
                QUERY: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // occ_hit is the map's answer to the strobe issued two cycles ago.
                    if (!bus.occ_hit) begin
                        pos_x <= cand_x;
                        pos_y <= cand_y;
                        valid <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (last_try) begin
                        valid <= 1'b1;
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tries <= tries + 1'b1;
                        state <= DRAW;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy;
    assign bus.valid   = valid;
    assign bus.fail    = fail;
    assign bus.pos_x   = pos_x;
    assign bus.pos_y   = pos_y;
    assign bus.occ_req = occ_req;
    assign bus.occ_x   = occ_x;
    assign bus.occ_y   = occ_y;
endmodule
